// File: rtl/mriscv_pkg.sv
// Shared RV32I decode definitions: opcode and func3 constants, the decode FSM
// states and the registered bundle handed from decode to execute.
package mriscv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_reg;
    logic        is_alu;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] branch_dest;
    logic [31:0] store_data;
    logic [31:0] curr_pc;
    logic [4:0]  dest;
    logic [2:0]  func3;
    logic        func7;
  } decode_out_t;

  function automatic logic is_known_opcode(input logic [6:0] opc);
    return opc inside {LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), sign-extended to 32 bits.
// Only instr[31:7] carries immediate bits, so the opcode field is not connected.
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] i_imm,
  output logic [31:0] s_imm,
  output logic [31:0] b_imm,
  output logic [31:0] u_imm,
  output logic [31:0] j_imm
);

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/decode.sv
// RV32I decode stage: one-entry pipeline register between fetch and execute.
// Define DECODE_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they pass as NOPs.
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_reg,
  output logic        is_alu,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] branch_dest,
  output logic [31:0] store_data,
  output logic [31:0] curr_pc,
  output logic [4:0]  dest,
  output logic [2:0]  func3,
  output logic        func7,
  input  logic        flush,
  output logic        illegal
);
  import mriscv_pkg::*;

  state_e      state_q, state_d;
  decode_out_t out_q, out_d, dec;
  logic        out_valid_q, out_valid_d;
  logic        illegal_q, illegal_d;
  logic        capture;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  imm_gen u_imm_gen (
    .instr (instr[31:7]),
    .i_imm (i_imm),
    .s_imm (s_imm),
    .b_imm (b_imm),
    .u_imm (u_imm),
    .j_imm (j_imm)
  );

  assign rs1_addr    = instr[19:15];
  assign rs2_addr    = instr[24:20];
  assign instr_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign capture     = instr_valid && instr_ready;

  // NOTE: every field gets a default before the case, so no path leaves a latch.
  always_comb begin
    dec         = '0;
    dec.curr_pc = instr_pc;
    dec.dest    = instr[11:7];
    dec.func3   = instr[14:12];
    case (instr[6:0])
      OP: begin
        dec.is_alu    = 1'b1;
        dec.is_reg    = 1'b1;
        dec.operand_a = rs1_data;
        dec.operand_b = rs2_data;
        dec.func7     = instr[30];
      end
      OP_IMM: begin
        dec.is_alu    = 1'b1;
        dec.operand_a = rs1_data;
        dec.operand_b = i_imm;
        // Only shifts use instr[30] (SRAI vs SRLI); for other ops it is immediate data.
        dec.func7     = (instr[14:12] == F3_SRL_SRA) ? instr[30] : 1'b0;
      end
      LUI, AUIPC: begin
        dec.is_alu    = 1'b1;
        dec.func3     = F3_ADD_SUB;
        dec.operand_a = (instr[6:0] == AUIPC) ? instr_pc : 32'd0;
        dec.operand_b = u_imm;
      end
      BRANCH: begin
        dec.is_branch   = 1'b1;
        dec.operand_a   = rs1_data;
        dec.operand_b   = rs2_data;
        dec.branch_dest = b_imm;
        dec.dest        = '0;
      end
      JAL: begin
        dec.is_jump   = 1'b1;
        dec.operand_a = j_imm;
      end
      JALR: begin
        dec.is_jump   = 1'b1;
        dec.is_reg    = 1'b1;
        dec.operand_a = rs1_data;
        dec.operand_b = i_imm;
      end
      LOAD: begin
        dec.is_load   = 1'b1;
        dec.operand_a = rs1_data;
        dec.operand_b = i_imm;
      end
      STORE: begin
        dec.is_store   = 1'b1;
        dec.operand_a  = rs1_data;
        dec.operand_b  = s_imm;
        dec.store_data = rs2_data;
        dec.dest       = '0;
      end
      default: begin
        dec.dest  = '0;
        dec.func3 = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (!is_known_opcode(instr[6:0])) begin
        illegal_d   = 1'b1;
        out_valid_d = 1'b0;
        state_d     = HALT;
      end else begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end
`else
      out_d       = dec;
      out_valid_d = 1'b1;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign illegal     = illegal_q;
  assign is_load     = out_q.is_load;
  assign is_store    = out_q.is_store;
  assign is_branch   = out_q.is_branch;
  assign is_jump     = out_q.is_jump;
  assign is_reg      = out_q.is_reg;
  assign is_alu      = out_q.is_alu;
  assign operand_a   = out_q.operand_a;
  assign operand_b   = out_q.operand_b;
  assign branch_dest = out_q.branch_dest;
  assign store_data  = out_q.store_data;
  assign curr_pc     = out_q.curr_pc;
  assign dest        = out_q.dest;
  assign func3       = out_q.func3;
  assign func7       = out_q.func7;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: stimulus pushes hand-computed bundles, a monitor
// pops and compares on every execute-side hand-off.
module tb_decode;

  typedef struct packed {
    logic [5:0]  flags;  // {load, store, branch, jump, reg, alu}
    logic [31:0] a, b, bd, sd, pc;
    logic [4:0]  dest;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready, out_valid, out_ready, flush, illegal;
  logic [31:0] instr, instr_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, dest;
  logic        is_load, is_store, is_branch, is_jump, is_reg, is_alu, func7;
  logic [31:0] operand_a, operand_b, branch_dest, store_data, curr_pc;
  logic [2:0]  func3;
  exp_t        act;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t  exp_q[$];
  string name_q[$];

  decode dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .is_reg(is_reg), .is_alu(is_alu), .operand_a(operand_a), .operand_b(operand_b),
    .branch_dest(branch_dest), .store_data(store_data), .curr_pc(curr_pc), .dest(dest),
    .func3(func3), .func7(func7), .flush(flush), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = '{flags: {is_load, is_store, is_branch, is_jump, is_reg, is_alu},
                 a: operand_a, b: operand_b, bd: branch_dest, sd: store_data, pc: curr_pc,
                 dest: dest, f3: func3, f7: func7};

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic exp_t mk(input logic [5:0] flags, input logic [31:0] a, b, bd, sd, pc,
                              input logic [4:0] d, input logic [2:0] f3, input logic f7);
    exp_t e;
    e = '{flags: flags, a: a, b: b, bd: bd, sd: sd, pc: pc, dest: d, f3: f3, f7: f7};
    return e;
  endfunction

  // Monitor: a hand-off is out_valid && out_ready outside reset and flush.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", act, '0);
      end else begin
        check(name_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  task automatic send(input string name, input logic [31:0] ins, pc, d1, d2,
                      input logic [9:0] exp_addr, input exp_t e, input bit emit);
    int waited = 0;
    instr = ins; instr_pc = pc; rs1_data = d1; rs2_data = d2; instr_valid = 1'b1;
    @(negedge clk);
    check({name, "_rsaddr"}, {rs1_addr, rs2_addr}, exp_addr);
    while (!instr_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      check({name, "_accept_timeout"}, instr_ready, 1'b1);
    end else begin
      @(posedge clk);
      if (emit) begin
        exp_q.push_back(e);
        name_q.push_back(name);
      end
      #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    exp_t e_sub;
    reset = 1'b1; instr_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    instr = '0; instr_pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {act, out_valid, illegal}, '0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", instr_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back stream: every capture after the first is also a hand-off.
    send("addi", 32'hFFD08293, 32'h100, 32'd10, 32'h77, {5'd1, 5'd29},
         mk(6'b000001, 32'd10, 32'hFFFFFFFD, 0, 0, 32'h100, 5'd5, 3'd0, 1'b0), 1);
    send("beq", 32'h00208863, 32'd20, 32'd5, 32'd7, {5'd1, 5'd2},
         mk(6'b001000, 32'd5, 32'd7, 32'd16, 0, 32'd20, 5'd0, 3'd0, 1'b0), 1);
    send("jal", 32'h008000EF, 32'h40, 32'h55, 32'h66, {5'd0, 5'd8},
         mk(6'b000100, 32'd8, 0, 0, 0, 32'h40, 5'd1, 3'd0, 1'b0), 1);
    send("srai", 32'h4043D313, 32'h44, 32'h80000000, 32'h99, {5'd7, 5'd4},
         mk(6'b000001, 32'h80000000, 32'h404, 0, 0, 32'h44, 5'd6, 3'd5, 1'b1), 1);
    send("addi_b30", 32'h40000093, 32'h48, 32'd0, 32'h12, {5'd0, 5'd0},
         mk(6'b000001, 0, 32'h400, 0, 0, 32'h48, 5'd1, 3'd0, 1'b0), 1);
    send("lui", 32'h123453B7, 32'h4C, 32'hAAAA, 32'hBBBB, {5'd8, 5'd3},
         mk(6'b000001, 0, 32'h12345000, 0, 0, 32'h4C, 5'd7, 3'd0, 1'b0), 1);
    send("auipc", 32'hFFFFF417, 32'h2000, 32'hCC, 32'hDD, {5'd31, 5'd31},
         mk(6'b000001, 32'h2000, 32'hFFFFF000, 0, 0, 32'h2000, 5'd8, 3'd0, 1'b0), 1);
    send("lw", 32'hFF812483, 32'h50, 32'h1000, 32'h3, {5'd2, 5'd24},
         mk(6'b100000, 32'h1000, 32'hFFFFFFF8, 0, 0, 32'h50, 5'd9, 3'd2, 1'b0), 1);
    send("sw", 32'hFE532E23, 32'h54, 32'h2000, 32'hDEADBEEF, {5'd6, 5'd5},
         mk(6'b010000, 32'h2000, 32'hFFFFFFFC, 0, 32'hDEADBEEF, 32'h54, 5'd0, 3'd2, 1'b0), 1);
    send("jalr", 32'h004280E7, 32'h58, 32'h300, 32'h11, {5'd5, 5'd4},
         mk(6'b000110, 32'h300, 32'd4, 0, 0, 32'h58, 5'd1, 3'd0, 1'b0), 1);
    send("bne", 32'hFE419CE3, 32'h5C, 32'd1, 32'd2, {5'd3, 5'd4},
         mk(6'b001000, 32'd1, 32'd2, 32'hFFFFFFF8, 0, 32'h5C, 5'd0, 3'd1, 1'b0), 1);
    drain();

    // Stall: sub is held for 3 cycles while a new instruction waits upstream.
    e_sub = mk(6'b000011, 32'd50, 32'd8, 0, 0, 32'h60, 5'd3, 3'd0, 1'b1);
    out_ready = 1'b0;
    send("sub", 32'h402081B3, 32'h60, 32'd50, 32'd8, {5'd1, 5'd2}, e_sub, 1);
    instr = 32'h123453B7; instr_pc = 32'h64; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", instr_ready, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      check("stall_hold", act, e_sub);
    end
    @(posedge clk); #1 instr_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    drain();

    // Flush with a held output and an incoming instruction: both disappear.
    out_ready = 1'b0;
    send("flush_held", 32'hFFD08293, 32'h70, 32'd1, 32'd2, {5'd1, 5'd29}, '0, 0);
    instr = 32'h008000EF; instr_pc = 32'h74; instr_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 1'b0);
    @(posedge clk); #1;

`ifdef DECODE_ILLEGAL_TRAP_EN
    send("illegal", 32'h00000000, 32'h3000, 32'd1, 32'd2, {5'd0, 5'd0}, '0, 0);
    @(negedge clk);
    check("illegal_flag", {illegal, instr_ready, out_valid}, 3'b100);
    instr = 32'hFFD08293; instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halt_sticky", {illegal, instr_ready, out_valid}, 3'b100);
    @(posedge clk); #1 instr_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("halt_reset", {illegal, instr_ready, out_valid}, 3'b010);
    @(posedge clk); #1;
`else
    send("nop", 32'h00000000, 32'h3000, 32'd1, 32'd2, {5'd0, 5'd0},
         mk(6'b000000, 0, 0, 0, 0, 32'h3000, 5'd0, 3'd0, 1'b0), 1);
    drain();
    check("nop_illegal", illegal, 1'b0);
`endif

    // Reset while stalled clears everything and re-opens the fetch side.
    out_ready = 1'b0;
    send("rst_held", 32'h402081B3, 32'h80, 32'd9, 32'd9, {5'd1, 5'd2}, '0, 0);
    @(negedge clk);
    check("rst_held_valid", out_valid, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midstall_reset", {act, out_valid, illegal, instr_ready}, 192'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    send("jal_post", 32'h008000EF, 32'h90, 32'h5, 32'h6, {5'd0, 5'd8},
         mk(6'b000100, 32'd8, 0, 0, 0, 32'h90, 5'd1, 3'd0, 1'b0), 1);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
